pipelined_dual_port_mem: RTL and testbench

Parametrised successor to the core's unified memory. One storage array serves two request channels: instruction fetch (port I, read-only) and load/store (port D, byte-masked writes). Both channels use a valid/ready request handshake and return responses after a fixed, configurable read latency. Memory-mapped signature and halt registers are decoded in hardware and exposed as ports, not handled as simulation side effects.

---
 rtl/pipelined_dual_port_mem.sv | 169 ++++++++++++++++
 tb/tb_pipelined_dual_port_mem.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_dual_port_mem.sv
// Unified instruction/data memory with two request channels sharing one array.
// Port I is a read-only fetch channel, port D does byte-masked loads/stores.
// Responses come back a fixed READ_LATENCY cycles after accept, in order.
// Signature and halt registers are decoded on port D writes and exported.
module pipelined_dual_port_mem #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          DMEM_SZ_IN_KB = 1,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] SIG_ADDR      = 32'h8E00_0000,
  parameter logic [31:0] HALT_ADDR     = 32'h8F00_0000
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      i_req_valid,
  output logic                      i_req_ready,
  input  logic [31:0]               i_addr,
  output logic                      i_rsp_valid,
  output logic [DATA_WIDTH-1:0]     i_rsp_data,
  output logic                      i_rsp_err,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic                      d_we,
  input  logic [DATA_WIDTH/8-1:0]   d_mask,
  input  logic [31:0]               d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_rsp_valid,
  output logic [DATA_WIDTH-1:0]     d_rsp_data,
  output logic                      d_rsp_err,
  output logic                      sig_valid,
  output logic [DATA_WIDTH-1:0]     sig_data,
  output logic                      halted
);

  localparam int ADDR_WIDTH = 32;
  localparam int AW1        = ADDR_WIDTH + 1;
  localparam int MASK_SIZE  = DATA_WIDTH / 8;
  localparam int OFF        = $clog2(MASK_SIZE);
  localparam int DEPTH      = DMEM_SZ_IN_KB * 1024 * 8 / DATA_WIDTH;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than an address so the upper bound cannot wrap.
  localparam logic [AW1-1:0] LIMIT = {1'b0, BASE_ADDR} + AW1'(DMEM_SZ_IN_KB * 1024);

  logic r_halted;
  logic r_sig_valid;
  logic [DATA_WIDTH-1:0] r_sig_data;

  logic w_i_fire, w_d_fire;
  logic w_i_inr, w_d_inr;
  logic w_d_sig, w_d_halt, w_d_mmio, w_d_wr_mem;
  logic [IDX_W-1:0] w_i_idx, w_d_idx;

  assign i_req_ready = !r_halted;
  assign d_req_ready = !r_halted;
  assign w_i_fire    = i_req_valid && !r_halted;
  assign w_d_fire    = d_req_valid && !r_halted;

  assign w_i_inr = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} < LIMIT);
  assign w_d_inr = (d_addr >= BASE_ADDR) && ({1'b0, d_addr} < LIMIT);
  assign w_i_idx = IDX_W'((i_addr - BASE_ADDR) >> OFF);
  assign w_d_idx = IDX_W'((d_addr - BASE_ADDR) >> OFF);

  assign w_d_sig    = (d_addr == SIG_ADDR);
  assign w_d_halt   = (d_addr == HALT_ADDR);
  assign w_d_mmio   = w_d_sig || w_d_halt;
  assign w_d_wr_mem = w_d_fire && d_we && w_d_inr && !w_d_mmio;

  // Per-port request classification: index 0 is port I, index 1 is port D.
  logic [1:0] w_fire, w_zero, w_err;
  assign w_fire[0] = w_i_fire;
  assign w_zero[0] = !w_i_inr;
  assign w_err[0]  = !w_i_inr;
  assign w_fire[1] = w_d_fire;
  assign w_zero[1] = d_we || !w_d_inr || w_d_mmio;
  assign w_err[1]  = !w_d_inr && !w_d_mmio;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_i_rd, r_d_rd;
  logic [DATA_WIDTH-1:0] w_rd [2];
  assign w_rd[0] = r_i_rd;
  assign w_rd[1] = r_d_rd;

  // Storage array: registered reads on both ports, byte-masked write from port D.
  // Reads see the pre-write contents when I and D hit the same word.
  always_ff @(posedge clk) begin
    r_i_rd <= r_mem[w_i_idx];
    r_d_rd <= r_mem[w_d_idx];
    for (int k = 0; k < MASK_SIZE; k++) begin
      if (w_d_wr_mem && d_mask[k]) begin
        r_mem[w_d_idx][k*8 +: 8] <= d_wdata[k*8 +: 8];
      end
    end
  end

  // Response pipeline taps, [port][stage]; the last stage drives the outputs.
  logic                  w_pv [2][READ_LATENCY];
  logic                  w_pe [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0] w_pd [2][READ_LATENCY];

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_s0
        logic r_v, r_e, r_z;
        // First stage rides alongside the registered array read.
        always_ff @(posedge clk or negedge arst_n) begin
          if (!arst_n) begin
            r_v <= 1'b0;
            r_e <= 1'b0;
            r_z <= 1'b1;
          end else begin
            r_v <= w_fire[gp];
            r_e <= w_fire[gp] && w_err[gp];
            r_z <= w_zero[gp];
          end
        end
        assign w_pv[gp][gi] = r_v;
        assign w_pe[gp][gi] = r_e;
        assign w_pd[gp][gi] = (r_v && !r_z) ? w_rd[gp] : '0;
      end else begin : g_sn
        logic r_v, r_e;
        logic [DATA_WIDTH-1:0] r_d;
        // Later stages just delay the already-formed response.
        always_ff @(posedge clk or negedge arst_n) begin
          if (!arst_n) begin
            r_v <= 1'b0;
            r_e <= 1'b0;
            r_d <= '0;
          end else begin
            r_v <= w_pv[gp][gi-1];
            r_e <= w_pe[gp][gi-1];
            r_d <= w_pd[gp][gi-1];
          end
        end
        assign w_pv[gp][gi] = r_v;
        assign w_pe[gp][gi] = r_e;
        assign w_pd[gp][gi] = r_d;
      end
    end
  end

  assign i_rsp_valid = w_pv[0][READ_LATENCY-1];
  assign i_rsp_err   = w_pe[0][READ_LATENCY-1];
  assign i_rsp_data  = w_pd[0][READ_LATENCY-1];
  assign d_rsp_valid = w_pv[1][READ_LATENCY-1];
  assign d_rsp_err   = w_pe[1][READ_LATENCY-1];
  assign d_rsp_data  = w_pd[1][READ_LATENCY-1];

  // MMIO side effects: signature pulse with held value, sticky halt.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sig_valid <= 1'b0;
      r_sig_data  <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_sig_valid <= w_d_fire && d_we && w_d_sig;
      if (w_d_fire && d_we && w_d_sig) begin
        r_sig_data <= d_wdata;
      end
      if (w_d_fire && d_we && w_d_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign sig_valid = r_sig_valid;
  assign sig_data  = r_sig_data;
  assign halted    = r_halted;

endmodule

// File: tb/tb_pipelined_dual_port_mem.sv
// Self-checking bench for pipelined_dual_port_mem with READ_LATENCY=2.
module tb_pipelined_dual_port_mem;
  localparam int          RL    = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] SIGA  = 32'h8E00_0000;
  localparam logic [31:0] HALTA = 32'h8F00_0000;
  localparam int          WORDS = 256;

  logic clk, arst_n;
  logic i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_addr, i_rsp_data;
  logic d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
  logic [3:0] d_mask;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic sig_valid, halted;
  logic [31:0] sig_data;

  pipelined_dual_port_mem #(
    .DATA_WIDTH(32), .DMEM_SZ_IN_KB(1), .BASE_ADDR(BASE),
    .READ_LATENCY(RL), .SIG_ADDR(SIGA), .HALT_ADDR(HALTA)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .sig_valid(sig_valid), .sig_data(sig_data), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: flat word array plus per-port queues of expected responses.
  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
  logic [31:0] mem_m [WORDS];
  rsp_t q_i[$];
  rsp_t q_d[$];
  bit   m_halted;
  int   cyc;
  int   n_checks;
  int   n_fails;

  function automatic bit in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 1024);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 32'h8000_0400 + ($urandom_range(0, 63) << 2);
    if (r == 1) return 32'h7FFF_FF00 + $urandom_range(0, 255);
    return BASE + ($urandom_range(64, WORDS - 1) << 2) + $urandom_range(0, 3);
  endfunction

  // Applies one cycle of requests, advances the model at the edge, samples at +1.
  task automatic drive(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                       input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dw);
    rsp_t r;
    logic [31:0] bm;
    bit mmio;
    i_req_valid = iv; i_addr = ia;
    d_req_valid = dv; d_we = dwe; d_mask = dm; d_addr = da; d_wdata = dw;
    @(posedge clk);
    cyc++;
    if (iv && !m_halted) begin
      r.due  = cyc + RL - 1;
      r.err  = !in_range(ia);
      r.data = r.err ? 32'h0 : mem_m[widx(ia)];
      q_i.push_back(r);
    end
    if (dv && !m_halted) begin
      mmio   = (da == SIGA) || (da == HALTA);
      r.due  = cyc + RL - 1;
      r.err  = !mmio && !in_range(da);
      r.data = 32'h0;
      if (!dwe && !mmio && !r.err) r.data = mem_m[widx(da)];
      if (dwe && da == HALTA) m_halted = 1'b1;
      if (dwe && !mmio && !r.err) begin
        bm = {{8{dm[3]}}, {8{dm[2]}}, {8{dm[1]}}, {8{dm[0]}}};
        mem_m[widx(da)] = (mem_m[widx(da)] & ~bm) | (dw & bm);
      end
      q_d.push_back(r);
    end
    #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err, i_rsp_data, d_rsp_data,
         sig_valid, sig_data, halted} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: got iv=%b dv=%b ie=%b de=%b id=%h dd=%h sv=%b sd=%h h=%b expected all 0",
               i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err, i_rsp_data, d_rsp_data,
               sig_valid, sig_data, halted);
    end
    arst_n = 1'b1;
    idle();
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b11) begin
      n_fails++;
      $display("FAIL reset_ready: got %b expected 11", {i_req_ready, d_req_ready});
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      n_checks++;
      if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin
        n_fails++;
        $display("FAIL idle_no_rsp: got %b expected 00", {i_rsp_valid, d_rsp_valid});
      end
    end
    $display("test_reset done");
  endtask

  // Known contents everywhere so later reads have defined expectations.
  task automatic test_init();
    for (int w = 0; w < WORDS; w++) drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, BASE + 32'(w * 4), 32'h0);
    repeat (RL) idle();
    $display("test_init wrote %0d words", WORDS);
  endtask

  task automatic test_write_read();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF);
    repeat (RL - 1) idle();
    n_checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL write_ack: got v=%b e=%b d=%h expected v=1 e=0 d=0", d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0);
    repeat (RL - 1) idle();
    n_checks++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fails++;
      $display("FAIL d_read_data: got v=%b d=%h expected v=1 d=deadbeef", d_rsp_valid, d_rsp_data);
    end
    idle();
    n_checks++;
    if (d_rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL rsp_pulse_width: got %b expected 0", d_rsp_valid);
    end
    drive(1'b1, 32'h8000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (RL - 1) idle();
    n_checks++;
    if ({i_rsp_valid, i_rsp_err, i_rsp_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fails++;
      $display("FAIL i_read_data: got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", i_rsp_valid, i_rsp_err, i_rsp_data);
    end
    idle();
    $display("test_write_read done");
  endtask

  task automatic test_byte_mask();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h8000_0004, 32'h1122_3344);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0110, 32'h8000_0004, 32'hAABB_CCDD);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0004, 32'h0);
    repeat (RL - 1) idle();
    n_checks++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'h11BB_CC44}) begin
      n_fails++;
      $display("FAIL byte_mask: got v=%b d=%h expected v=1 d=11bbcc44", d_rsp_valid, d_rsp_data);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h8000_0004, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0004, 32'h0);
    repeat (RL - 1) idle();
    n_checks++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'h11BB_CC44}) begin
      n_fails++;
      $display("FAIL zero_mask: got v=%b d=%h expected v=1 d=11bbcc44", d_rsp_valid, d_rsp_data);
    end
    idle();
    $display("test_byte_mask done");
  endtask

  task automatic test_collision_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    addrs[0] = 32'h8000_0010; addrs[1] = 32'h8000_0004; addrs[2] = 32'h8000_0020;
    exp_d[0] = 32'hDEAD_BEEF; exp_d[1] = 32'h11BB_CC44; exp_d[2] = 32'h5;
    // I read and D write of the same word in one cycle, then a D read the next.
    drive(1'b1, 32'h8000_0020, 1'b1, 1'b1, 4'hF, 32'h8000_0020, 32'h5);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0020, 32'h0);
    n_checks++;
    if ({i_rsp_valid, i_rsp_data} !== {1'b1, 32'h0}) begin
      n_fails++;
      $display("FAIL collision_old: got v=%b d=%h expected v=1 d=0", i_rsp_valid, i_rsp_data);
    end
    idle();
    n_checks++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'h5}) begin
      n_fails++;
      $display("FAIL collision_new: got v=%b d=%h expected v=1 d=5", d_rsp_valid, d_rsp_data);
    end
    idle();
    // Three reads on both ports in consecutive cycles: one response per cycle.
    for (int k = 0; k < 3 + RL; k++) begin
      if (k < 3) drive(1'b1, addrs[k], 1'b1, 1'b0, 4'h0, addrs[k], 32'h0);
      else idle();
      if (k >= RL - 1 && k < RL + 2) begin
        n_checks++;
        if ({i_rsp_valid, i_rsp_data, d_rsp_valid, d_rsp_data} !== {1'b1, exp_d[k-RL+1], 1'b1, exp_d[k-RL+1]}) begin
          n_fails++;
          $display("FAIL b2b_rsp%0d: got iv=%b id=%h dv=%b dd=%h expected v=1 d=%h",
                   k - RL + 1, i_rsp_valid, i_rsp_data, d_rsp_valid, d_rsp_data, exp_d[k-RL+1]);
        end
      end else begin
        n_checks++;
        if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin
          n_fails++;
          $display("FAIL b2b_gap%0d: got %b expected 00", k, {i_rsp_valid, d_rsp_valid});
        end
      end
    end
    $display("test_collision_back_to_back done");
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 32'h7FFF_FFFC, 1'b1, 1'b1, 4'hF, 32'h8000_0400, 32'hFFFF_FFFF);
    repeat (RL - 1) idle();
    n_checks++;
    if ({i_rsp_valid, i_rsp_err, i_rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
      n_fails++;
      $display("FAIL oor_i_below: got v=%b e=%b d=%h expected v=1 e=1 d=0", i_rsp_valid, i_rsp_err, i_rsp_data);
    end
    n_checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
      n_fails++;
      $display("FAIL oor_d_above: got v=%b e=%b d=%h expected v=1 e=1 d=0", d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    // Last word is in range; word 0 must not have been touched by the rejected write.
    drive(1'b1, 32'h8000_03FC, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
    repeat (RL - 1) idle();
    n_checks++;
    if ({i_rsp_valid, i_rsp_err} !== 2'b10) begin
      n_fails++;
      $display("FAIL last_word_in_range: got v=%b e=%b expected v=1 e=0", i_rsp_valid, i_rsp_err);
    end
    n_checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL word0_unchanged: got v=%b e=%b d=%h expected v=1 e=0 d=0", d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    drive(1'b1, 32'h8000_0400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (RL - 1) idle();
    n_checks++;
    if ({i_rsp_valid, i_rsp_err, i_rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
      n_fails++;
      $display("FAIL oor_i_end: got v=%b e=%b d=%h expected v=1 e=1 d=0", i_rsp_valid, i_rsp_err, i_rsp_data);
    end
    idle();
    $display("test_out_of_range done");
  endtask

  task automatic test_random();
    int n_rsp;
    rsp_t e;
    bit ev;
    n_rsp = 0;
    q_i.delete();
    q_d.delete();
    for (int k = 0; k < 400; k++) begin
      if (k < 400 - RL)
        drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), rand_addr(), $urandom);
      else
        idle();
      ev = (q_i.size() > 0) && (q_i[0].due == cyc);
      n_checks++;
      if (i_rsp_valid !== ev) begin
        n_fails++;
        $display("FAIL rand_i_valid cyc %0d: got %b expected %b", cyc, i_rsp_valid, ev);
      end
      if (ev) begin
        e = q_i.pop_front();
        n_rsp++;
        n_checks++;
        if ({i_rsp_err, i_rsp_data} !== {e.err, e.data}) begin
          n_fails++;
          $display("FAIL rand_i_rsp cyc %0d: got e=%b d=%h expected e=%b d=%h", cyc, i_rsp_err, i_rsp_data, e.err, e.data);
        end
      end
      ev = (q_d.size() > 0) && (q_d[0].due == cyc);
      n_checks++;
      if (d_rsp_valid !== ev) begin
        n_fails++;
        $display("FAIL rand_d_valid cyc %0d: got %b expected %b", cyc, d_rsp_valid, ev);
      end
      if (ev) begin
        e = q_d.pop_front();
        n_rsp++;
        n_checks++;
        if ({d_rsp_err, d_rsp_data} !== {e.err, e.data}) begin
          n_fails++;
          $display("FAIL rand_d_rsp cyc %0d: got e=%b d=%h expected e=%b d=%h", cyc, d_rsp_err, d_rsp_data, e.err, e.data);
        end
      end
    end
    n_checks++;
    if (q_i.size() + q_d.size() != 0) begin
      n_fails++;
      $display("FAIL rand_drain: got %0d outstanding expected 0", q_i.size() + q_d.size());
    end
    $display("test_random done, %0d responses", n_rsp);
  endtask

  task automatic test_sig_halt();
    logic [31:0] exp_rd;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, SIGA, 32'h1);
    n_checks++;
    if ({sig_valid, sig_data} !== {1'b1, 32'h1}) begin
      n_fails++;
      $display("FAIL sig_first: got v=%b d=%h expected v=1 d=1", sig_valid, sig_data);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, SIGA, 32'h2);
    n_checks++;
    if ({sig_valid, sig_data} !== {1'b1, 32'h2}) begin
      n_fails++;
      $display("FAIL sig_second: got v=%b d=%h expected v=1 d=2", sig_valid, sig_data);
    end
    n_checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL sig_ack: got v=%b e=%b d=%h expected v=1 e=0 d=0", d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    idle();
    n_checks++;
    if ({sig_valid, halted} !== 2'b00) begin
      n_fails++;
      $display("FAIL sig_pulse_end: got sv=%b h=%b expected 00", sig_valid, halted);
    end
    idle();
    exp_rd = mem_m[4];
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, HALTA, 32'h0);
    n_checks++;
    if ({halted, i_req_ready, d_req_ready} !== 3'b100) begin
      n_fails++;
      $display("FAIL halt_set: got h=%b ir=%b dr=%b expected h=1 ir=0 dr=0", halted, i_req_ready, d_req_ready);
    end
    n_checks++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b1, exp_rd}) begin
      n_fails++;
      $display("FAIL halt_drain: got v=%b d=%h expected v=1 d=%h", d_rsp_valid, d_rsp_data, exp_rd);
    end
    idle();
    n_checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b1, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL halt_ack: got v=%b e=%b d=%h expected v=1 e=0 d=0", d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    drive(1'b1, BASE, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
    for (int k = 0; k < RL + 1; k++) begin
      idle();
      n_checks++;
      if ({i_rsp_valid, d_rsp_valid, halted} !== 3'b001) begin
        n_fails++;
        $display("FAIL halted_no_accept%0d: got iv=%b dv=%b h=%b expected 0 0 1", k, i_rsp_valid, d_rsp_valid, halted);
      end
    end
    $display("test_sig_halt done");
  endtask

  task automatic test_reset_midop();
    arst_n = 1'b0;
    #2;
    n_checks++;
    if ({halted, sig_valid} !== 2'b00) begin
      n_fails++;
      $display("FAIL reset_clears_halt: got h=%b sv=%b expected 00", halted, sig_valid);
    end
    arst_n = 1'b1;
    q_i.delete(); q_d.delete(); m_halted = 1'b0;
    idle();
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b11) begin
      n_fails++;
      $display("FAIL ready_after_reset: got %b expected 11", {i_req_ready, d_req_ready});
    end
    drive(1'b1, 32'h8000_0010, 1'b1, 1'b0, 4'h0, 32'h8000_0004, 32'h0);
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    q_i.delete(); q_d.delete();
    for (int k = 0; k < RL + 1; k++) begin
      idle();
      n_checks++;
      if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin
        n_fails++;
        $display("FAIL reset_discard%0d: got %b expected 00", k, {i_rsp_valid, d_rsp_valid});
      end
    end
    $display("test_reset_midop done");
  endtask

  initial begin
    n_checks = 0; n_fails = 0; cyc = 0; m_halted = 1'b0;
    arst_n = 1'b0;
    i_req_valid = 1'b0; i_addr = 32'h0;
    d_req_valid = 1'b0; d_we = 1'b0; d_mask = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_collision_back_to_back();
    test_out_of_range();
    test_random();
    test_sig_halt();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
